// File: rtl/issue_scoreboard_pkg.sv
// Shared types and constants for the issue scoreboard.
// The top-level design reads the ISSUE_SCOREBOARD_WB_BYPASS_EN macro.
package issue_scoreboard_pkg;

    localparam int unsigned REG_ADDR_W       = 5;
    localparam int unsigned PAYLOAD_W        = 32;
    localparam int unsigned NUM_REGS         = 32;
    localparam int unsigned MAX_INFLIGHT_DEF = 4;
    localparam int unsigned INFLIGHT_W       = 4;

    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // One-hot register mask; x0 and disabled requests give an all-zero mask.
    function automatic logic [NUM_REGS-1:0] reg_onehot(
        input logic [REG_ADDR_W-1:0] addr,
        input logic                  en
    );
        reg_onehot = '0;
        if (en && (addr != X0)) begin
            reg_onehot[addr] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/issue_scoreboard_issue_slot.sv
// Single registered issue slot with valid/ready handshake and flush.
module issue_scoreboard_issue_slot
    import issue_scoreboard_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_load,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic [PAYLOAD_W-1:0]  i_payload,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic                  o_free,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic [PAYLOAD_W-1:0]  o_payload
);

    slot_state_e           r_state;
    slot_state_e           w_state_nxt;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic [PAYLOAD_W-1:0]  r_payload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = SLOT_EMPTY;
        end else if (i_load) begin
            w_state_nxt = SLOT_FULL;
        end else if ((r_state == SLOT_FULL) && i_ready) begin
            w_state_nxt = SLOT_EMPTY;
        end
    end

    // Data only moves on a load, so it holds steady under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr <= '0;
            r_payload <= '0;
        end else if (i_load && !i_flush) begin
            r_rd_addr <= i_rd_addr;
            r_payload <= i_payload;
        end
    end

    assign o_valid   = (r_state == SLOT_FULL);
    assign o_free    = !o_valid || i_ready;
    assign o_rd_addr = r_rd_addr;
    assign o_payload = r_payload;

endmodule

// File: rtl/issue_scoreboard.sv
// Register scoreboard and issue controller between decode and execute.
// Define ISSUE_SCOREBOARD_WB_BYPASS_EN to let a same-cycle writeback clear hazards.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int unsigned STALL_CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_dec_valid,
    output logic                   o_dec_ready,
    input  logic [REG_ADDR_W-1:0]  i_dec_rs1_address,
    input  logic [REG_ADDR_W-1:0]  i_dec_rs2_address,
    input  logic                   i_dec_rs1_used,
    input  logic                   i_dec_rs2_used,
    input  logic [REG_ADDR_W-1:0]  i_dec_rd_address,
    input  logic                   i_dec_rd_write_enable,
    input  logic [PAYLOAD_W-1:0]   i_dec_payload,
    output logic                   o_issue_valid,
    input  logic                   i_issue_ready,
    output logic [REG_ADDR_W-1:0]  o_issue_rd_address,
    output logic [PAYLOAD_W-1:0]   o_issue_payload,
    input  logic                   i_wb_valid,
    input  logic [REG_ADDR_W-1:0]  i_wb_rd_address,
    input  logic                   i_flush,
    output logic [INFLIGHT_W-1:0]  o_inflight_count,
    output logic [STALL_CNT_W-1:0] o_stall_count
);

    localparam logic [INFLIGHT_W-1:0] MAX_CNT = INFLIGHT_W'(MAX_INFLIGHT);

    logic [NUM_REGS-1:0]    r_pending;
    logic [INFLIGHT_W-1:0]  r_inflight;
    logic [STALL_CNT_W-1:0] r_stall;

    logic [NUM_REGS-1:0]    w_wb_mask;
    logic [NUM_REGS-1:0]    w_set_mask;
    logic [NUM_REGS-1:0]    w_hz_pending;
    logic [INFLIGHT_W-1:0]  w_hz_count;
    logic                   w_wb_clear;
    logic                   w_rd_tracked;
    logic                   w_hazard;
    logic                   w_slot_free;
    logic                   w_accept;
    logic                   w_track;

    // A writeback only retires a writer if its register is actually pending.
    assign w_wb_mask  = reg_onehot(i_wb_rd_address, i_wb_valid);
    assign w_wb_clear = |(w_wb_mask & r_pending);

`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
    assign w_hz_pending = r_pending & ~w_wb_mask;
    assign w_hz_count   = r_inflight - INFLIGHT_W'(w_wb_clear);
`else
    assign w_hz_pending = r_pending;
    assign w_hz_count   = r_inflight;
`endif

    assign w_rd_tracked = i_dec_rd_write_enable && (i_dec_rd_address != X0);

    assign w_hazard = (i_dec_rs1_used && w_hz_pending[i_dec_rs1_address])
                   || (i_dec_rs2_used && w_hz_pending[i_dec_rs2_address])
                   || (w_rd_tracked   && w_hz_pending[i_dec_rd_address])
                   || (w_rd_tracked   && (w_hz_count >= MAX_CNT));

    assign o_dec_ready = w_slot_free && !w_hazard && !i_flush;
    assign w_accept    = i_dec_valid && o_dec_ready;
    assign w_track     = w_accept && w_rd_tracked;
    assign w_set_mask  = reg_onehot(i_dec_rd_address, w_track);

    issue_scoreboard_issue_slot u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (i_flush),
        .i_load    (w_accept),
        .i_rd_addr (i_dec_rd_address),
        .i_payload (i_dec_payload),
        .i_ready   (i_issue_ready),
        .o_valid   (o_issue_valid),
        .o_free    (w_slot_free),
        .o_rd_addr (o_issue_rd_address),
        .o_payload (o_issue_payload)
    );

    // Clear before set so a new writer of a retiring register stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else if (i_flush) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_wb_mask) | w_set_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else if (i_flush) begin
            r_inflight <= '0;
        end else begin
            case ({w_track, w_wb_clear})
                2'b10:   r_inflight <= r_inflight + INFLIGHT_W'(1);
                2'b01:   r_inflight <= r_inflight - INFLIGHT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (i_dec_valid && w_slot_free && w_hazard && !i_flush
                     && (r_stall != '1)) begin
            r_stall <= r_stall + STALL_CNT_W'(1);
        end
    end

    assign o_inflight_count = r_inflight;
    assign o_stall_count    = r_stall;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard bench for issue_scoreboard: directed decode/writeback vectors,
// expected issues queued at acceptance and checked by an independent monitor.
module tb_issue_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_dec_valid = 1'b0;
    logic        o_dec_ready;
    logic [4:0]  i_dec_rs1_address = '0;
    logic [4:0]  i_dec_rs2_address = '0;
    logic        i_dec_rs1_used = 1'b0;
    logic        i_dec_rs2_used = 1'b0;
    logic [4:0]  i_dec_rd_address = '0;
    logic        i_dec_rd_write_enable = 1'b0;
    logic [31:0] i_dec_payload = '0;
    logic        o_issue_valid;
    logic        i_issue_ready = 1'b1;
    logic [4:0]  o_issue_rd_address;
    logic [31:0] o_issue_payload;
    logic        i_wb_valid = 1'b0;
    logic [4:0]  i_wb_rd_address = '0;
    logic        i_flush = 1'b0;
    logic [3:0]  o_inflight_count;
    logic [31:0] o_stall_count;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] payload;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned exp_stall = 0;

    issue_scoreboard #(.MAX_INFLIGHT(4), .STALL_CNT_W(32)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .i_dec_valid           (i_dec_valid),
        .o_dec_ready           (o_dec_ready),
        .i_dec_rs1_address     (i_dec_rs1_address),
        .i_dec_rs2_address     (i_dec_rs2_address),
        .i_dec_rs1_used        (i_dec_rs1_used),
        .i_dec_rs2_used        (i_dec_rs2_used),
        .i_dec_rd_address      (i_dec_rd_address),
        .i_dec_rd_write_enable (i_dec_rd_write_enable),
        .i_dec_payload         (i_dec_payload),
        .o_issue_valid         (o_issue_valid),
        .i_issue_ready         (i_issue_ready),
        .o_issue_rd_address    (o_issue_rd_address),
        .o_issue_payload       (o_issue_payload),
        .i_wb_valid            (i_wb_valid),
        .i_wb_rd_address       (i_wb_rd_address),
        .i_flush               (i_flush),
        .o_inflight_count      (o_inflight_count),
        .o_stall_count         (o_stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic dec(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic we,
                       input logic [31:0] pl);
        i_dec_valid           = 1'b1;
        i_dec_rs1_address     = rs1;
        i_dec_rs1_used        = u1;
        i_dec_rs2_address     = rs2;
        i_dec_rs2_used        = u2;
        i_dec_rd_address      = rd;
        i_dec_rd_write_enable = we;
        i_dec_payload         = pl;
    endtask

    task automatic idle();
        i_dec_valid = 1'b0;
    endtask

    // Presents an instruction expected to be accepted this cycle.
    task automatic issue_one(input string name, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                             input logic we, input logic [31:0] pl);
        dec(rs1, u1, rs2, u2, rd, we, pl);
        at_neg();
        chk(name, 64'(o_dec_ready), 64'd1);
        exp_q.push_back('{rd: rd, payload: pl});
        step();
    endtask

    task automatic wb_one(input logic [4:0] addr);
        i_wb_valid      = 1'b1;
        i_wb_rd_address = addr;
        step();
        i_wb_valid      = 1'b0;
    endtask

    // Monitor: every handshake on the issue port must match the next queued entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && o_issue_valid && i_issue_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue actual rd=%0d payload=%0h required none",
                             o_issue_rd_address, o_issue_payload);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_rd", 64'(o_issue_rd_address), 64'(e.rd));
                    chk("issue_payload", 64'(o_issue_payload), 64'(e.payload));
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        at_neg();
        chk("rst_issue_valid", 64'(o_issue_valid), 64'd0);
        chk("rst_issue_rd", 64'(o_issue_rd_address), 64'd0);
        chk("rst_issue_payload", 64'(o_issue_payload), 64'd0);
        chk("rst_inflight", 64'(o_inflight_count), 64'd0);
        chk("rst_stall", 64'(o_stall_count), 64'd0);
        chk("rst_dec_ready", 64'(o_dec_ready), 64'd1);
        step();

        // First instruction: rs1=1, rs2=2, rd=3
        issue_one("t1_ready", 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 32'hA000_0001);
        idle();
        at_neg();
        chk("t1_issue_valid", 64'(o_issue_valid), 64'd1);
        chk("t1_inflight", 64'(o_inflight_count), 64'd1);
        step();
        wb_one(5'd3);
        at_neg();
        chk("t1_inflight_after_wb", 64'(o_inflight_count), 64'd0);
        step();

        // RAW hazard on x5
        issue_one("t2_writer", 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 32'hB000_0005);
        dec(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'hB000_0105);
        at_neg();
        chk("t2_stall_ready1", 64'(o_dec_ready), 64'd0);
        step();
        exp_stall++;
        at_neg();
        chk("t2_stall_ready2", 64'(o_dec_ready), 64'd0);
        chk("t2_stall_cnt1", 64'(o_stall_count), 64'(exp_stall));
        step();
        exp_stall++;
        i_wb_valid      = 1'b1;
        i_wb_rd_address = 5'd5;
`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
        at_neg();
        chk("t2_bypass_ready", 64'(o_dec_ready), 64'd1);
        exp_q.push_back('{rd: 5'd0, payload: 32'hB000_0105});
        step();
        i_wb_valid = 1'b0;
`else
        at_neg();
        chk("t2_wb_cycle_ready", 64'(o_dec_ready), 64'd0);
        step();
        exp_stall++;
        i_wb_valid = 1'b0;
        issue_one("t2_after_wb_ready", 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'hB000_0105);
`endif
        idle();
        at_neg();
        chk("t2_stall_total", 64'(o_stall_count), 64'(exp_stall));
        chk("t2_inflight", 64'(o_inflight_count), 64'd0);
        step();

        // Writer limit: x1..x4 then x6
        for (int i = 1; i <= 4; i++) begin
            issue_one("t3_writer", 5'd0, 1'b0, 5'd0, 1'b0, 5'(i), 1'b1, 32'hC000_0000 + 32'(i));
        end
        dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 32'hC000_0006);
        at_neg();
        chk("t3_limit_ready", 64'(o_dec_ready), 64'd0);
        chk("t3_limit_count", 64'(o_inflight_count), 64'd4);
        step();
        exp_stall++;
        at_neg();
        chk("t3_limit_ready2", 64'(o_dec_ready), 64'd0);
        step();
        exp_stall++;
        i_wb_valid      = 1'b1;
        i_wb_rd_address = 5'd2;
`ifdef ISSUE_SCOREBOARD_WB_BYPASS_EN
        at_neg();
        chk("t3_bypass_ready", 64'(o_dec_ready), 64'd1);
        exp_q.push_back('{rd: 5'd6, payload: 32'hC000_0006});
        step();
        i_wb_valid = 1'b0;
`else
        at_neg();
        chk("t3_wb_cycle_ready", 64'(o_dec_ready), 64'd0);
        step();
        exp_stall++;
        i_wb_valid = 1'b0;
        issue_one("t3_fifth_ready", 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 32'hC000_0006);
`endif
        idle();
        at_neg();
        chk("t3_count_after", 64'(o_inflight_count), 64'd4);
        chk("t3_stall_total", 64'(o_stall_count), 64'(exp_stall));
        step();
        wb_one(5'd2);
        at_neg();
        chk("t3_wb_not_pending", 64'(o_inflight_count), 64'd4);
        step();
        wb_one(5'd1);
        wb_one(5'd3);
        wb_one(5'd4);
        wb_one(5'd6);
        at_neg();
        chk("t3_drained", 64'(o_inflight_count), 64'd0);
        step();

        // Writes to x0 are never tracked
        for (int i = 0; i < 10; i++) begin
            issue_one("t4_x0_ready", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 32'hD000_0000 + 32'(i));
        end
        idle();
        at_neg();
        chk("t4_inflight", 64'(o_inflight_count), 64'd0);
        chk("t4_stall", 64'(o_stall_count), 64'(exp_stall));
        step();

        // Backpressure holds the slot steady
        i_issue_ready = 1'b0;
        issue_one("t5_first_ready", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'hE000_0001);
        dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'hE000_0002);
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("t5_bp_ready", 64'(o_dec_ready), 64'd0);
            chk("t5_bp_valid", 64'(o_issue_valid), 64'd1);
            chk("t5_bp_payload", 64'(o_issue_payload), 64'hE000_0001);
            step();
        end
        at_neg();
        chk("t5_bp_stall", 64'(o_stall_count), 64'(exp_stall));
        step();
        i_issue_ready = 1'b1;
        issue_one("t5_release_ready", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'hE000_0002);
        idle();
        at_neg();
        step();

        // Flush with pending x7, x8 and simultaneous WB x7
        issue_one("t6_w7_ready", 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 32'hF000_0007);
        issue_one("t6_w8_ready", 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 32'hF000_0008);
        idle();
        i_issue_ready   = 1'b0;
        i_flush         = 1'b1;
        i_wb_valid      = 1'b1;
        i_wb_rd_address = 5'd7;
        at_neg();
        chk("t6_flush_ready", 64'(o_dec_ready), 64'd0);
        chk("t6_pre_inflight", 64'(o_inflight_count), 64'd2);
        chk("t6_pre_valid", 64'(o_issue_valid), 64'd1);
        step();
        void'(exp_q.pop_back());
        i_flush       = 1'b0;
        i_wb_valid    = 1'b0;
        i_issue_ready = 1'b1;
        dec(5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'hF000_0108);
        at_neg();
        chk("t6_post_valid", 64'(o_issue_valid), 64'd0);
        chk("t6_post_inflight", 64'(o_inflight_count), 64'd0);
        chk("t6_reader_ready", 64'(o_dec_ready), 64'd1);
        exp_q.push_back('{rd: 5'd0, payload: 32'hF000_0108});
        step();
        idle();
        at_neg();
        chk("t6_stall_kept", 64'(o_stall_count), 64'(exp_stall));
        step();

        repeat (3) step();
        at_neg();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
